stream_join_buf: RTL and testbench

STREAM_JOIN_BUF -- requirements
Module: stream_join_buf

---
 rtl/stream_join_buf_pkg.sv | 21 ++
 rtl/stream_join_buf_slot.sv | 51 +++++
 rtl/stream_join_buf.sv | 51 +++++
 tb/tb_stream_join_buf.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stream_join_buf_pkg.sv
// Shared stream typedefs: handshake pair, slot state and helpers used by the
// join buffer and its per-input slot.
package stream_join_buf_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic valid;
    logic ready;
  } stream_hs_t;

  localparam int N_INP_MAX = 32;

  function automatic logic hs_fire(input stream_hs_t hs);
    return hs.valid & hs.ready;
  endfunction

endpackage

// File: rtl/stream_join_buf_slot.sv
// One join slot: EMPTY/FULL state plus the captured beat. A FULL slot
// re-opens in the same cycle the joined beat leaves (pass-through refill).
module stream_join_slot
  import stream_join_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic                  out_fire_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  slot_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  stream_hs_t            in_hs;
  logic                  in_fire;

  always_comb begin
    ready_o       = (state_q == EMPTY) | out_fire_i;
    in_hs.valid   = in_valid_i;
    in_hs.ready   = ready_o;
    in_fire       = hs_fire(in_hs);
    state_d       = state_q;
    data_d        = data_q;
    if (in_fire) begin
      state_d = FULL;
      data_d  = data_i;
    end else if (out_fire_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign full_o = (state_q == FULL);
  assign data_o = data_q;

endmodule

// File: rtl/stream_join_buf.sv
// Joins N_INP independent valid/ready streams into one beat; each input owns
// a one-entry slot, and the joined beat is driven straight from the slot regs.
module stream_join_buf
  import stream_join_buf_pkg::*;
#(
  parameter int N_INP      = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_INP-1:0]              valid_i,
  output logic [N_INP-1:0]              ready_o,
  input  logic [N_INP*DATA_WIDTH-1:0]   data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [N_INP*DATA_WIDTH-1:0]   data_o
);

  if (N_INP < 1 || N_INP > N_INP_MAX || DATA_WIDTH < 1) begin : g_bad_params
    $fatal(1, "stream_join_buf: illegal N_INP=%0d / DATA_WIDTH=%0d", N_INP, DATA_WIDTH);
  end

  logic [N_INP-1:0] full;
  stream_hs_t       out_hs;
  logic             out_fire;

  // out_fire depends only on slot state and ready_i, never on valid_i
  always_comb begin
    out_hs.valid = &full;
    out_hs.ready = ready_i;
    out_fire     = hs_fire(out_hs);
  end

  assign valid_o = &full;

  for (genvar i = 0; i < N_INP; i++) begin : g_slot
    stream_join_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .in_valid_i (valid_i[i]),
      .out_fire_i (out_fire),
      .data_i     (data_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .ready_o    (ready_o[i]),
      .full_o     (full[i]),
      .data_o     (data_o[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_stream_join_buf.sv
// Scoreboard bench for stream_join_buf (N_INP=2, DATA_WIDTH=8): accepted input
// beats are queued per input and popped against data_o on each output handshake.
module tb_stream_join_buf;

  localparam int N = 2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] valid_i;
  logic [N-1:0] ready_o;
  logic [N*W-1:0] data_i;
  logic         valid_o;
  logic         ready_i;
  logic [N*W-1:0] data_o;

  int errors = 0;
  int checks = 0;
  int in_cnt0 = 0;
  int in_cnt1 = 0;
  int out_cnt = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  always #5 clk = ~clk;

  stream_join_buf #(
    .N_INP      (N),
    .DATA_WIDTH (W)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus in the low phase, check, update the model,
  // then advance to the next falling edge.
  task automatic step(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic rdy);
    logic       exp_valid;
    logic       fire;
    logic [1:0] exp_rdy;
    valid_i = v;
    data_i  = {d1, d0};
    ready_i = rdy;
    #1;
    exp_valid = (q0.size() > 0) && (q1.size() > 0);
    fire      = exp_valid && rdy;
    exp_rdy   = {(q1.size() == 0) || fire, (q0.size() == 0) || fire};
    check("valid_o", valid_o, exp_valid);
    check("ready_o", ready_o, exp_rdy);
    if (exp_valid) check("data_o", data_o, {q1[0], q0[0]});
    if (fire) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
      out_cnt++;
    end
    if (v[0] && exp_rdy[0]) begin
      q0.push_back(d0);
      in_cnt0++;
    end
    if (v[1] && exp_rdy[1]) begin
      q1.push_back(d1);
      in_cnt1++;
    end
    @(negedge clk);
  endtask

  initial begin
    int base_out, base_in0, base_in1, exp_min;
    rst     = 1'b1;
    valid_i = '0;
    data_i  = '0;
    ready_i = 1'b0;
    @(negedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_ready", ready_o, 2'b11);
    @(negedge clk);
    rst = 1'b0;

    // both inputs together, first edge after reset release
    step(2'b11, 8'hA1, 8'hB2, 1'b1);
    check("basic_valid", valid_o, 1);
    check("basic_data", data_o, 16'hB2A1);
    step(2'b00, 8'h00, 8'h00, 1'b1);
    check("basic_drain", valid_o, 0);

    // staggered inputs
    step(2'b01, 8'h11, 8'h00, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      check("stag_rdy0", ready_o[0], 0);
      check("stag_valid_lo", valid_o, 0);
      if (c == 3) step(2'b10, 8'h00, 8'h22, 1'b1);
      else        step(2'b00, 8'h00, 8'h00, 1'b1);
    end
    check("stag_valid_hi", valid_o, 1);
    check("stag_data", data_o, 16'h2211);
    step(2'b00, 8'h00, 8'h00, 1'b1);
    check("stag_drain", valid_o, 0);

    // backpressure with new data waiting
    step(2'b11, 8'h33, 8'h44, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(2'b11, 8'h55, 8'h66, 1'b0);
      check("bp_valid", valid_o, 1);
      check("bp_data", data_o, 16'h4433);
      check("bp_ready", ready_o, 2'b00);
    end
    step(2'b11, 8'h55, 8'h66, 1'b1);
    check("bp_next_valid", valid_o, 1);
    check("bp_next_data", data_o, 16'h6655);
    step(2'b00, 8'h00, 8'h00, 1'b1);
    check("bp_drain", valid_o, 0);

    // streaming, one beat per cycle
    base_out = out_cnt;
    for (int i = 0; i < 100; i++) begin
      step(2'b11, 8'(i), 8'(i) ^ 8'hFF, 1'b1);
      check("stream_valid", valid_o, 1);
    end
    step(2'b00, 8'h00, 8'h00, 1'b1);
    check("stream_cnt", out_cnt - base_out, 100);

    // asynchronous reset with slot 0 holding 0x55
    step(2'b01, 8'h55, 8'h00, 1'b1);
    valid_i = '0;
    rst     = 1'b1;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_data", data_o, 0);
    check("arst_ready", ready_o, 2'b11);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    step(2'b01, 8'h77, 8'h00, 1'b1);
    check("arst_no_beat", valid_o, 0);
    step(2'b10, 8'h00, 8'h88, 1'b1);
    check("arst_data_new", data_o, 16'h8877);
    step(2'b00, 8'h00, 8'h00, 1'b1);

    // random valid/ready traffic
    base_out = out_cnt;
    base_in0 = in_cnt0;
    base_in1 = in_cnt1;
    for (int c = 0; c < 10000; c++) begin
      step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int c = 0; c < 3; c++) step(2'b00, 8'h00, 8'h00, 1'b1);
    exp_min = (in_cnt0 - base_in0 < in_cnt1 - base_in1) ? in_cnt0 - base_in0 : in_cnt1 - base_in1;
    check("rnd_cnt", out_cnt - base_out, exp_min);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
